asinx: RTL and testbench
========================

# asinx

Iterative inverse-sine converter: accepts a 6-bit quantised sine sample on `analog` and returns the 12-bit quarter-wave angle code on `digital` whose quantised sine matches it. It is the reverse path of the forward sine converter in the analog-test FPGA design (12-bit angle in, 6-bit sine out). It lets the bench close the loop angle → sine → angle on hardware. The result is produced by a 12-step successive-approximation search against a registered sine ROM, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `ANGLE_W`, 12: angle code width; code d represents θ = d·π/(2·2^ANGLE_W), which covers [0, π/2).
- `SINE_W`, 6: sine code width; sinq(d) = floor(sin(θ)·2^SINE_W), always ≤ 2^SINE_W−1.

Ports:
- `clk`  in  1  system clock; the block uses one clock only.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `analog` is valid.
- `in_ready`  out  1  block can accept a sample.
- `analog`  in  SINE_W  sine code to invert.
- `out_valid`  out  1  `digital` holds a result.
- `out_ready`  in  1  consumer takes the result.
- `digital`  out  ANGLE_W  angle code result.

## Operation
- Result definition: `digital` = the largest d in [0, 2^ANGLE_W−1] with sinq(d) ≤ `analog`. sinq is monotonic on the quarter wave, so the MSB-first search is exact.
- FSM states:
  - IDLE:
    - `in_ready`=1.
    - On `in_valid`&&`in_ready`, capture `analog` into `target`, clear `result`, set `bit_idx`=ANGLE_W−1, then go to TRIAL.
  - TRIAL:
    - Present `trial` = `result` | (1<<`bit_idx`) to the sine ROM address register, then go to COMPARE.
  - COMPARE:
    - If ROM data ≤ `target`, set `result`[`bit_idx`]=1.
    - If `bit_idx`==0, go to DONE; otherwise decrement `bit_idx` and go to TRIAL.
  - DONE:
    - `out_valid`=1 and `digital`=`result`, held stable.
    - On `out_ready`, go to IDLE.
- `in_ready` is 0 in every state except IDLE. A sample offered while the block is busy is not taken.
- `in_valid` is ignored outside IDLE, and `analog` is sampled only on the accept cycle.
- `out_valid` and `digital` must not change while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: `in_ready`=1 (state IDLE), `out_valid`=0, `digital`=0, internal `result`=0, `target`=0, `bit_idx`=ANGLE_W−1.
- Reset asserted in any state overrides everything. In the next cycle the block is in IDLE, any search in progress is discarded, and no output is produced for it.
- Sine ROM is registered: an address presented in TRIAL gives valid data in COMPARE, one cycle later.
- Latency: accept edge at cycle 0, then TRIAL/COMPARE pairs at cycles 1–24, then `out_valid` rises at cycle 25 (2·ANGLE_W+1).
- Throughput:
  - If `out_ready` is held at 1, `out_valid` lasts one cycle and `in_ready` returns the next cycle.
  - Minimum spacing between accepts is 26 cycles.
- If `out_ready` and the DONE entry occur in the same cycle, no transfer happens until `out_valid` is visible. A handshake needs `out_valid`=1 registered.

## Configuration
- `ASINX_EARLY_EXIT_EN` defined:
  - An accepted `analog` == 2^SINE_W−1 skips the search and goes straight to DONE with `result`=2^ANGLE_W−1.
  - `out_valid` rises at cycle 1 after accept.
  - All other codes behave as without the macro.
- Not defined: every sample takes the full 25-cycle search. The numeric result is identical either way.

## Structure
- Shared package `asinx_pkg` holds:
  - the FSM state enum (IDLE, TRIAL, COMPARE, DONE);
  - default `ANGLE_W`/`SINE_W` constants;
  - the sinq scaling constant used for ROM generation.
- Sub-module `sin_quarter_rom`:
  - 2^ANGLE_W × SINE_W synchronous ROM with registered address, 1-cycle read latency;
  - contents are sinq(d), generated at elaboration.
- The top level holds the FSM, `target`/`result`/`bit_idx` registers and the handshake logic.

## Test plan
- Reset then `analog`=0 accepted → `out_valid` at cycle 25 with `digital`=40 (sinq(40)=0, sinq(41)=1).
- `analog`=32 → `digital`=1412. `analog`=63 → `digital`=4095; with `ASINX_EARLY_EXIT_EN`, `out_valid` at cycle 1.
- `out_ready` held at 0 for 10 cycles after `out_valid` → `digital` stays stable and `in_ready` stays 0. A new `in_valid` pulse during this time is not accepted.
- Assert `rst` for 1 cycle at cycle 12 of a search → next cycle: IDLE, `in_ready`=1, `out_valid`=0. The aborted sample never appears at the output.
- Sweep all 64 `analog` codes back-to-back with `out_ready`=1 → each result d satisfies sinq(d) ≤ `analog` < sinq(d+1) (or d=4095), against a reference model. Accepts are spaced exactly 26 cycles apart.

Source files
------------

// File: rtl/asinx_pkg.sv
// Shared types and constants for the asinx inverse-sine converter.
package asinx_pkg;

   localparam int  ANGLE_W_DEF = 12;
   localparam int  SINE_W_DEF  = 6;
   // Full-scale multiplier for the default sine width (2**SINE_W_DEF).
   localparam real SINQ_SCALE  = 64.0;
   localparam real PI_R        = 3.14159265358979323846;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TRIAL   = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/asinx_sin_quarter_rom.sv
// Quarter-wave sine ROM: entry d holds floor(sin(d*pi/(2*2^ANGLE_W))*2^SINE_W),
// built at elaboration; the address is registered, so data trails it by one cycle.
module sin_quarter_rom
   import asinx_pkg::*;
#(
   parameter int ANGLE_W = ANGLE_W_DEF,
   parameter int SINE_W  = SINE_W_DEF
) (
   input  logic               clk,
   input  logic [ANGLE_W-1:0] i_addr,
   output logic [SINE_W-1:0]  o_data
);

   localparam int  DEPTH = 2 ** ANGLE_W;
   localparam int  MAXV  = (2 ** SINE_W) - 1;
   localparam real SCALE = SINQ_SCALE * real'(2 ** SINE_W) / real'(2 ** SINE_W_DEF);

   logic [SINE_W-1:0]  w_tab [DEPTH];
   logic [ANGLE_W-1:0] r_addr;

   for (genvar g = 0; g < DEPTH; g++) begin : g_tab
      localparam real TH  = PI_R * real'(g) / (2.0 * real'(DEPTH));
      localparam int  RAW = $rtoi($sin(TH) * SCALE);
      localparam int  VAL = (RAW > MAXV) ? MAXV : RAW;
      localparam logic [SINE_W-1:0] CODE = SINE_W'(VAL);
      assign w_tab[g] = CODE;
   end

   always_ff @(posedge clk) begin
      r_addr <= i_addr;
   end

   assign o_data = w_tab[r_addr];

endmodule

// File: rtl/asinx.sv
// Inverse-sine converter: MSB-first successive approximation of the angle code
// against the sine ROM. Optional macro ASINX_EARLY_EXIT_EN short-cuts full-scale input.
module asinx
   import asinx_pkg::*;
#(
   parameter int ANGLE_W = ANGLE_W_DEF,
   parameter int SINE_W  = SINE_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SINE_W-1:0]  analog,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ANGLE_W-1:0] digital
);

   localparam int IDX_W = $clog2(ANGLE_W);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(ANGLE_W - 1);

   state_t             r_state, w_state_nxt;
   logic [SINE_W-1:0]  r_target, w_target_nxt;
   logic [ANGLE_W-1:0] r_result, w_result_nxt;
   logic [ANGLE_W-1:0] r_digital, w_digital_nxt;
   logic [IDX_W-1:0]   r_bit_idx, w_bit_idx_nxt;
   logic               r_in_ready, r_out_valid;
   logic [ANGLE_W-1:0] w_one_hot, w_trial;
   logic [SINE_W-1:0]  w_rom_data;
   logic               w_accept;

   assign w_one_hot = {{(ANGLE_W-1){1'b0}}, 1'b1} << r_bit_idx;
   assign w_trial   = r_result | w_one_hot;
   assign w_accept  = in_valid && r_in_ready;

   // ROM captures the trial address every cycle; only the TRIAL-cycle value is consumed.
   sin_quarter_rom #(
      .ANGLE_W (ANGLE_W),
      .SINE_W  (SINE_W)
   ) u_rom (
      .clk    (clk),
      .i_addr (w_trial),
      .o_data (w_rom_data)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_target_nxt  = r_target;
      w_result_nxt  = r_result;
      w_bit_idx_nxt = r_bit_idx;
      w_digital_nxt = r_digital;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_target_nxt  = analog;
               w_result_nxt  = {ANGLE_W{1'b0}};
               w_bit_idx_nxt = IDX_TOP;
               w_state_nxt   = ST_TRIAL;
`ifdef ASINX_EARLY_EXIT_EN
               if (analog == {SINE_W{1'b1}}) begin
                  w_result_nxt  = {ANGLE_W{1'b1}};
                  w_digital_nxt = {ANGLE_W{1'b1}};
                  w_state_nxt   = ST_DONE;
               end else begin
                  w_state_nxt   = ST_TRIAL;
               end
`endif
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_TRIAL: begin
            w_state_nxt = ST_COMPARE;
         end
         ST_COMPARE: begin
            if (w_rom_data <= r_target) begin
               w_result_nxt = r_result | w_one_hot;
            end else begin
               w_result_nxt = r_result;
            end
            if (r_bit_idx == {IDX_W{1'b0}}) begin
               w_digital_nxt = w_result_nxt;
               w_state_nxt   = ST_DONE;
            end else begin
               w_bit_idx_nxt = r_bit_idx - IDX_W'(1);
               w_state_nxt   = ST_TRIAL;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Handshake flags are registered from the next state so they track r_state exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_target    <= {SINE_W{1'b0}};
         r_result    <= {ANGLE_W{1'b0}};
         r_digital   <= {ANGLE_W{1'b0}};
         r_bit_idx   <= IDX_TOP;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_target    <= w_target_nxt;
         r_result    <= w_result_nxt;
         r_digital   <= w_digital_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_in_ready  <= (w_state_nxt == ST_IDLE);
         r_out_valid <= (w_state_nxt == ST_DONE);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign digital   = r_digital;

endmodule

// File: tb/tb_asinx.sv
// Self-checking bench for asinx: reference angle from a sine table computed with $sin.
module tb_asinx;

   localparam int NA = 4096;
`ifdef ASINX_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  analog;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] digital;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int sinq_ref [NA];

   asinx dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .analog    (analog),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .digital   (digital)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_angle(input int a);
      for (int d = NA - 1; d >= 0; d--) begin
         if (sinq_ref[d] <= a) return d;
      end
      return 0;
   endfunction

   function automatic int ref_latency(input int a);
      return (EARLY && a == 63) ? 1 : 25;
   endfunction

   // Present one sample on the accept edge, then scramble analog.
   task automatic accept(input int a);
      in_valid = 1'b1;
      analog   = 6'(a);
      step();
      in_valid = 1'b0;
      analog   = 6'($urandom_range(0, 63));
   endtask

   task automatic wait_out(output int lat, output bit ok);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
      ok = (out_valid === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; analog = 6'd0;
      step(); step();
      rst = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_tests++;
      if (digital !== 12'd0) begin n_fail++; $display("FAIL reset_digital got %0d want 0", digital); end
   endtask

   task automatic test_known();
      int codes [3] = '{0, 32, 63};
      int wants [3] = '{40, 1412, 4095};
      int lat;
      bit ok;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL known_ready a=%0d got %b want 1", codes[k], in_ready); end
         accept(codes[k]);
         wait_out(lat, ok);
         n_tests++;
         if (!ok) begin n_fail++; $display("FAIL known_timeout a=%0d got no out_valid want out_valid", codes[k]); end
         n_tests++;
         if (lat != ref_latency(codes[k])) begin n_fail++; $display("FAIL known_latency a=%0d got %0d want %0d", codes[k], lat, ref_latency(codes[k])); end
         n_tests++;
         if (int'(digital) != wants[k]) begin n_fail++; $display("FAIL known_digital a=%0d got %0d want %0d", codes[k], digital, wants[k]); end
         step();
         n_tests++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL known_release a=%0d got v=%b r=%b want v=0 r=1", codes[k], out_valid, in_ready);
         end
      end
   endtask

   task automatic test_hold();
      int  a = $urandom_range(0, 62);
      int  e = ref_angle(a);
      int  lat;
      bit  ok;
      bit  spurious = 1'b0;
      out_ready = 1'b0;
      accept(a);
      wait_out(lat, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL hold_timeout a=%0d got no out_valid want out_valid", a); end
      for (int i = 0; i < 10; i++) begin
         in_valid = (i == 3);
         analog   = 6'(63 - a);
         step();
         n_tests++;
         if (int'(digital) != e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable cyc%0d got d=%0d v=%b r=%b want d=%0d v=1 r=0", i, digital, out_valid, in_ready, e);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL hold_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
      end
      repeat (30) begin
         step();
         if (out_valid === 1'b1) spurious = 1'b1;
      end
      n_tests++;
      if (spurious) begin n_fail++; $display("FAIL hold_ignored_pulse got out_valid=1 want no output"); end
   endtask

   task automatic test_reset_abort();
      int a = $urandom_range(0, 62);
      bit spurious = 1'b0;
      out_ready = 1'b1;
      accept(a);
      repeat (11) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL abort_state got r=%b v=%b want r=1 v=0", in_ready, out_valid);
      end
      repeat (30) begin
         step();
         if (out_valid === 1'b1) spurious = 1'b1;
      end
      n_tests++;
      if (spurious) begin n_fail++; $display("FAIL abort_no_output got out_valid=1 want none"); end
   endtask

   task automatic test_back_to_back();
      int codes [64];
      int prev_t = 0;
      int prev_a = 0;
      int t, a, d, lat, guard, tmp, j;
      bit ok;
      for (int i = 0; i < 64; i++) codes[i] = i;
      for (int i = 63; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = codes[i]; codes[i] = codes[j]; codes[j] = tmp;
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 64; k++) begin
         a = codes[k];
         analog = 6'(a);
         guard = 0;
         while (in_ready !== 1'b1 && guard < 40) begin step(); guard++; end
         n_tests++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_timeout a=%0d got r=%b want 1", a, in_ready); end
         t = cyc;
         step();
         analog = 6'($urandom_range(0, 63));
         wait_out(lat, ok);
         d = int'(digital);
         n_tests++;
         if (!ok) begin n_fail++; $display("FAIL b2b_timeout a=%0d got no out_valid want out_valid", a); end
         n_tests++;
         if (d != ref_angle(a)) begin n_fail++; $display("FAIL b2b_digital a=%0d got %0d want %0d", a, d, ref_angle(a)); end
         n_tests++;
         if (!(sinq_ref[d] <= a && (d == NA - 1 || a < sinq_ref[d + 1]))) begin
            n_fail++; $display("FAIL b2b_bracket a=%0d got d=%0d sinq=%0d want sinq(d)<=a<sinq(d+1)", a, d, sinq_ref[d]);
         end
         if (k > 0) begin
            n_tests++;
            if (t - prev_t != ((EARLY && prev_a == 63) ? 2 : 26)) begin
               n_fail++; $display("FAIL b2b_spacing a=%0d got %0d want %0d", a, t - prev_t, (EARLY && prev_a == 63) ? 2 : 26);
            end
         end
         prev_t = t;
         prev_a = a;
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_random();
      int a, e, lat, dly;
      bit ok;
      for (int k = 0; k < 16; k++) begin
         a = $urandom_range(0, 63);
         e = ref_angle(a);
         dly = $urandom_range(0, 3);
         out_ready = 1'b0;
         accept(a);
         wait_out(lat, ok);
         n_tests++;
         if (!ok || int'(digital) != e) begin
            n_fail++; $display("FAIL rand_digital a=%0d got v=%b d=%0d want v=1 d=%0d", a, out_valid, digital, e);
         end
         repeat (dly) step();
         n_tests++;
         if (out_valid !== 1'b1 || int'(digital) != e) begin
            n_fail++; $display("FAIL rand_stall a=%0d got v=%b d=%0d want v=1 d=%0d", a, out_valid, digital, e);
         end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
   endtask

   initial begin
      for (int d = 0; d < NA; d++) begin
         sinq_ref[d] = $rtoi($sin(real'(d) * 3.14159265358979323846 / 8192.0) * 64.0);
         if (sinq_ref[d] > 63) sinq_ref[d] = 63;
      end
      test_reset();
      test_known();
      test_hold();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
